// File: rtl/parity_serial_tx_pkg.sv
// Shared FSM encoding and parity-mode constants for the serial parity transmitter/receiver.
package parity_serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DATA   = 2'b01,
        PARITY = 2'b10
    } state_t;

    // Parity bit makes the total number of ones in the frame even.
    localparam bit EVEN_ONES = 1'b1;

    // Parity bit to transmit given the running XOR of the data bits.
    function automatic logic parity_bit(input logic ones_odd);
        return EVEN_ONES ? ones_odd : ~ones_odd;
    endfunction

endpackage

// File: rtl/parity_serial_tx_if.sv
// Load handshake and serial output bundle of the parity transmitter.
interface parity_serial_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] data;
    logic             ready;
    logic             x;
    logic             x_valid;
    logic             done;
    logic             ones_odd;

    modport master (
        output start, data,
        input  ready, x, x_valid, done, ones_odd
    );

    modport slave (
        input  start, data,
        output ready, x, x_valid, done, ones_odd
    );
endinterface

// File: rtl/parity_accum.sv
// Running XOR of transmitted/received bits; shared by the serial parity TX and RX.
module parity_accum (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic ones_odd
);

    // Clear has priority so a new frame always starts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ones_odd <= 1'b0;
        end else if (clr) begin
            ones_odd <= 1'b0;
        end else if (en) begin
            ones_odd <= ones_odd ^ bit_in;
        end
    end

endmodule

// File: rtl/parity_serial_tx.sv
// Parallel-load serial transmitter: WIDTH data bits followed by one even-ones parity bit.
module parity_serial_tx
    import parity_serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    parity_serial_tx_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;
    logic               head;
    logic               accept;
    logic               shift_en;
    logic               ones_odd;
    logic               ready;
    logic               x;
    logic               x_valid;
    logic               done;

    assign head     = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign accept   = (state == IDLE) && bus.start;
    assign shift_en = (state == DATA);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shift register and bit counter; data is only sampled on acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= bus.data;
            cnt   <= '0;
        end else if (shift_en) begin
            shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            cnt   <= cnt + CNT_W'(1);
        end
    end

    parity_accum u_accum (
        .clk      (clk),
        .reset    (reset),
        .clr      (accept),
        .en       (shift_en),
        .bit_in   (head),
        .ones_odd (ones_odd)
    );

    // Next state and outputs, decoded from registered state only.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        x         = 1'b0;
        x_valid   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.start) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                x_valid = 1'b1;
                x       = head;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = PARITY;
                end
            end
            PARITY: begin
                x_valid   = 1'b1;
                x         = parity_bit(ones_odd);
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.ready    = ready;
    assign bus.x        = x;
    assign bus.x_valid  = x_valid;
    assign bus.done     = done;
    assign bus.ones_odd = ones_odd;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed and scoreboard bench for parity_serial_tx (MSB-first and LSB-first instances).
module tb_parity_serial_tx;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] data;
    int         compared;
    int         mismatched;

    parity_serial_tx_if #(.WIDTH(8)) ifm ();
    parity_serial_tx_if #(.WIDTH(8)) ifl ();

    assign ifm.start = start;
    assign ifm.data  = data;
    assign ifl.start = start;
    assign ifl.data  = data;

    parity_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (ifm)
    );

    parity_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (ifl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Idle-state output check for the selected instance.
    task automatic chk_idle(input string tag, input logic sel);
        chk1({tag, "_ready"},   sel ? ifl.ready   : ifm.ready,   1'b1);
        chk1({tag, "_x_valid"}, sel ? ifl.x_valid : ifm.x_valid, 1'b0);
        chk1({tag, "_done"},    sel ? ifl.done    : ifm.done,    1'b0);
        chk1({tag, "_x"},       sel ? ifl.x       : ifm.x,       1'b0);
    endtask

    // Called at the negedge of the first data cycle; ends at the negedge of the following idle cycle.
    task automatic check_frame(input string tag, input logic sel, input logic [7:0] seq,
                               input logic par, input logic odd);
        for (int i = 0; i < 8; i++) begin
            chk1({tag, "_x"},       sel ? ifl.x       : ifm.x,       seq[7-i]);
            chk1({tag, "_x_valid"}, sel ? ifl.x_valid : ifm.x_valid, 1'b1);
            chk1({tag, "_ready"},   sel ? ifl.ready   : ifm.ready,   1'b0);
            chk1({tag, "_done"},    sel ? ifl.done    : ifm.done,    1'b0);
            @(negedge clk);
        end
        chk1({tag, "_par"},      sel ? ifl.x        : ifm.x,        par);
        chk1({tag, "_par_done"}, sel ? ifl.done     : ifm.done,     1'b1);
        chk1({tag, "_par_vld"},  sel ? ifl.x_valid  : ifm.x_valid,  1'b1);
        chk1({tag, "_par_rdy"},  sel ? ifl.ready    : ifm.ready,    1'b0);
        chk1({tag, "_odd"},      sel ? ifl.ones_odd : ifm.ones_odd, odd);
        @(negedge clk);
        chk_idle({tag, "_end"}, sel);
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] rx;
        int         ones;
        int         nvalid;

        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        start      = 1'b0;
        data       = 8'h00;

        // Reset state
        #3;
        chk_idle("rst_m", 1'b0);
        chk1("rst_odd", ifm.ones_odd, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("post_rst", 1'b0);

        // A5 MSB first; data changed after acceptance must not matter
        start = 1'b1; data = 8'hA5;
        @(negedge clk);
        start = 1'b0; data = 8'h5A;
        check_frame("a5", 1'b0, 8'b1010_0101, 1'b0, 1'b0);

        // 07: last three bits 1, parity 1
        start = 1'b1; data = 8'h07;
        @(negedge clk);
        start = 1'b0;
        check_frame("h07", 1'b0, 8'b0000_0111, 1'b1, 1'b1);
        chk1("h07_hold_odd", ifm.ones_odd, 1'b1);

        // 00: nine zeros
        start = 1'b1; data = 8'h00;
        @(negedge clk);
        start = 1'b0;
        check_frame("h00", 1'b0, 8'b0000_0000, 1'b0, 1'b0);

        // LSB first, 01: first bit 1, parity 1
        start = 1'b1; data = 8'h01;
        @(negedge clk);
        start = 1'b0;
        check_frame("lsb01", 1'b1, 8'b1000_0000, 1'b1, 1'b1);

        // Start held high: FF, 80, 3C back-to-back with a one-cycle gap
        start = 1'b1; data = 8'hFF;
        @(negedge clk);
        data = 8'h80;
        check_frame("b2b_ff", 1'b0, 8'b1111_1111, 1'b0, 1'b0);
        @(negedge clk);
        data = 8'h3C;
        check_frame("b2b_80", 1'b0, 8'b1000_0000, 1'b1, 1'b1);
        @(negedge clk);
        start = 1'b0;
        check_frame("b2b_3c", 1'b0, 8'b0011_1100, 1'b0, 1'b0);
        @(negedge clk);
        chk_idle("b2b_stop", 1'b0);

        // Start pulse in cycle 4 of a frame is ignored
        start = 1'b1; data = 8'hC3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                start = 1'b1; data = 8'hFF;
            end else begin
                start = 1'b0;
            end
            chk1("ign_x", ifm.x, w_c3_bit(i));
            chk1("ign_vld", ifm.x_valid, 1'b1);
            @(negedge clk);
        end
        chk1("ign_par", ifm.x, 1'b0);
        chk1("ign_done", ifm.done, 1'b1);
        @(negedge clk);
        chk_idle("ign_idle1", 1'b0);
        @(negedge clk);
        chk_idle("ign_idle2", 1'b0);

        // Reset in cycle 5 aborts the frame immediately
        start = 1'b1; data = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1("abort_pre_vld", ifm.x_valid, 1'b1);
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        chk_idle("abort_now", 1'b0);
        chk1("abort_odd", ifm.ones_odd, 1'b0);
        @(negedge clk);
        chk_idle("abort_hold", 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("abort_rel", 1'b0);
        start = 1'b1; data = 8'h01;
        @(negedge clk);
        start = 1'b0;
        check_frame("after_rst", 1'b0, 8'b0000_0001, 1'b1, 1'b1);

        // Receiver-model scoreboard over random words
        for (int n = 0; n < 1000; n++) begin
            w     = 8'($urandom_range(0, 255));
            start = 1'b1; data = w;
            @(negedge clk);
            start = 1'b0; data = 8'($urandom_range(0, 255));
            rx = 8'h00; ones = 0; nvalid = 0;
            for (int i = 0; i < 9; i++) begin
                if (ifm.x_valid === 1'b1) begin
                    nvalid++;
                    ones += int'(ifm.x);
                    if (i < 8) rx = {rx[6:0], ifm.x};
                end
                @(negedge clk);
            end
            chk8("sb_data", rx, w);
            chk1("sb_even", 1'(ones % 2), 1'b0);
            chk8("sb_nvalid", 8'(nvalid), 8'd9);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Transmission-order bits of C3 (1100_0011), MSB first.
    function automatic logic w_c3_bit(input int i);
        logic [7:0] v;
        v = 8'b1100_0011;
        return v[7-i];
    endfunction

endmodule
